ffsr_update_sched: RTL

- Shares one pulse-encoded FFSR weight register between NUM_REQ update sources, e.g. STDP learning units that emit inc/dec events.
- Per requester, buffers pending net updates in saturating signed counters.
- Round-robin arbitration issues at most one single-cycle inc or dec pulse every two cycles to the FFSR.
- Sequences FFSR (re)initialisation and keeps a shadow copy of the FFSR value so it never wraps past 0 or max.

---
 rtl/ffsr_update_sched.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ffsr_update_sched.sv
// Round-robin scheduler sharing one pulse-driven FFSR weight register between NUM_REQ update sources.
// Optional FFSR_SCHED_STATS_EN adds a saturating drop_cnt output counting discarded events.
module ffsr_update_sched #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned INPUT_SIZE = 8,
  parameter int unsigned PEND_W     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [INPUT_SIZE-1:0]      init,
  input  logic [NUM_REQ-1:0]         inc_req,
  input  logic [NUM_REQ-1:0]         dec_req,
  output logic                       ffsr_inc,
  output logic                       ffsr_dec,
  output logic                       ffsr_rst,
  output logic [INPUT_SIZE-1:0]      ffsr_init,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
`ifdef FFSR_SCHED_STATS_EN
  output logic [15:0]                drop_cnt,
`endif
  output logic [INPUT_SIZE-1:0]      shadow
);

  localparam int unsigned IDW  = $clog2(NUM_REQ);
  localparam int          PMAX = (2 ** (PEND_W - 1)) - 1;
  localparam int          PMIN = -(2 ** (PEND_W - 1));

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, GAP} state_t;

  state_t                    state_q, state_d;
  logic signed [PEND_W-1:0]  pend_q [NUM_REQ];
  logic signed [PEND_W-1:0]  pend_d [NUM_REQ];
  logic [IDW-1:0]            ptr_q, ptr_d;
  logic                      lpend_q, lpend_d;
  logic [INPUT_SIZE-1:0]     init_hold_q, init_hold_d;
  logic                      ffsr_inc_d, ffsr_dec_d, ffsr_rst_d, busy_d;
  logic [INPUT_SIZE-1:0]     ffsr_init_d, shadow_d, ld_val;
  logic [IDW-1:0]            grant_d, win;
  logic                      found, any_nz, any_nz_d, do_load, do_issue, bdrop;
  int                        idx, iss, sum, drops;
`ifdef FFSR_SCHED_STATS_EN
  logic [15:0]               drop_cnt_d;
  int                        dsum;
`endif

  // Round-robin winner: first nonzero counter at or after the pointer
  always_comb begin
    found  = 1'b0;
    win    = '0;
    idx    = 0;
    any_nz = 1'b0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = (int'(ptr_q) + k) % int'(NUM_REQ);
      if (!found && pend_q[idx] != '0) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
      if (pend_q[k] != '0) any_nz = 1'b1;
    end
  end

  // Next-state, issue, pending-counter and shadow logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lpend_d     = lpend_q;
    init_hold_d = init_hold_q;
    ffsr_inc_d  = 1'b0;
    ffsr_dec_d  = 1'b0;
    ffsr_rst_d  = 1'b0;
    ffsr_init_d = ffsr_init;
    grant_d     = grant_id;
    shadow_d    = shadow;
    do_load     = 1'b0;
    do_issue    = 1'b0;
    bdrop       = 1'b0;
    iss         = 0;
    sum         = 0;
    drops       = 0;
    ld_val      = init;
    any_nz_d    = 1'b0;
    busy_d      = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) pend_d[i] = pend_q[i];

    case (state_q)
      IDLE: begin
        if (load) do_load = 1'b1;
        else if (any_nz) do_issue = 1'b1;
      end
      LOAD:  state_d = IDLE;
      ISSUE: begin
        state_d = GAP;
        if (load) begin
          lpend_d     = 1'b1;
          init_hold_d = init;
        end
      end
      GAP: begin
        if (load || lpend_q) do_load = 1'b1;
        else if (any_nz) do_issue = 1'b1;
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (do_load) begin
      ld_val      = lpend_q ? init_hold_q : init;
      state_d     = LOAD;
      lpend_d     = 1'b0;
      ffsr_rst_d  = 1'b1;
      ffsr_init_d = ld_val;
      shadow_d    = ld_val;
    end

    // Shadow bounds turn an issue slot into a dropped event instead of a wrap
    if (do_issue) begin
      state_d = ISSUE;
      grant_d = win;
      ptr_d   = (int'(win) == int'(NUM_REQ) - 1) ? '0 : IDW'(int'(win) + 1);
      if (pend_q[win] > 0) begin
        iss = 1;
        if (shadow != '1) begin
          ffsr_inc_d = 1'b1;
          shadow_d   = shadow + 1'b1;
        end else bdrop = 1'b1;
      end else begin
        iss = -1;
        if (shadow != '0) begin
          ffsr_dec_d = 1'b1;
          shadow_d   = shadow - 1'b1;
        end else bdrop = 1'b1;
      end
    end

    for (int i = 0; i < int'(NUM_REQ); i++) begin
      sum = int'(pend_q[i]) + int'(inc_req[i]) - int'(dec_req[i]);
      if (do_issue && int'(win) == i) sum = sum - iss;
      if (sum > PMAX) begin
        pend_d[i] = PEND_W'(PMAX);
        drops     = drops + (sum - PMAX);
      end else if (sum < PMIN) begin
        pend_d[i] = PEND_W'(PMIN);
        drops     = drops + (PMIN - sum);
      end else begin
        pend_d[i] = PEND_W'(sum);
      end
      if (pend_d[i] != '0) any_nz_d = 1'b1;
    end
    if (bdrop) drops = drops + 1;

    busy_d = (state_d != IDLE) || any_nz_d;
  end

`ifdef FFSR_SCHED_STATS_EN
  always_comb begin
    dsum       = int'(drop_cnt) + drops;
    drop_cnt_d = (dsum > 65535) ? 16'hFFFF : 16'(dsum);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      lpend_q     <= 1'b0;
      init_hold_q <= '0;
      ffsr_inc    <= 1'b0;
      ffsr_dec    <= 1'b0;
      ffsr_rst    <= 1'b0;
      ffsr_init   <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      shadow      <= '0;
      for (int i = 0; i < int'(NUM_REQ); i++) pend_q[i] <= '0;
`ifdef FFSR_SCHED_STATS_EN
      drop_cnt    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lpend_q     <= lpend_d;
      init_hold_q <= init_hold_d;
      ffsr_inc    <= ffsr_inc_d;
      ffsr_dec    <= ffsr_dec_d;
      ffsr_rst    <= ffsr_rst_d;
      ffsr_init   <= ffsr_init_d;
      grant_id    <= grant_d;
      busy        <= busy_d;
      shadow      <= shadow_d;
      for (int i = 0; i < int'(NUM_REQ); i++) pend_q[i] <= pend_d[i];
`ifdef FFSR_SCHED_STATS_EN
      drop_cnt    <= drop_cnt_d;
`endif
    end
  end

endmodule
